// File: rtl/dir_mon_pkg.sv
// Shared types for the directory write-request monitor: record kinds,
// the packed capture record and field-width constants.
package dir_mon_pkg;

  localparam int unsigned PAYLOAD_W = 21;
  localparam int unsigned SET_W     = 9;
  localparam int unsigned WAY_W     = 3;
  localparam int unsigned TIME_W    = 32;
  localparam int unsigned NUM_CH    = 4;

  typedef enum logic [1:0] {
    DIR  = 2'd0,
    TAG  = 2'd1,
    CDIR = 2'd2,
    CTAG = 2'd3
  } wreq_kind_e;

  // Everything captured from a channel except the time stamp.
  typedef struct packed {
    wreq_kind_e             kind;
    logic [SET_W-1:0]       set;
    logic [WAY_W-1:0]       way;
    logic [PAYLOAD_W-1:0]   payload;
  } wreq_body_t;

  typedef struct packed {
    wreq_kind_e             kind;
    logic [SET_W-1:0]       set;
    logic [WAY_W-1:0]       way;
    logic [PAYLOAD_W-1:0]   payload;
    logic [TIME_W-1:0]      stamp;
  } wreq_rec_t;

  localparam int unsigned BODY_W = $bits(wreq_body_t);
  localparam int unsigned REC_W  = $bits(wreq_rec_t);

endpackage

// File: rtl/wreq_multi_fifo.sv
// FIFO accepting up to NW writes per cycle into consecutive slots and
// draining one entry per cycle; head data reads as zero while empty.
module wreq_multi_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 35,
  parameter int unsigned NW    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [$clog2(NW+1)-1:0]    wr_cnt,
  input  logic [NW-1:0][DW-1:0]      wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          pop;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign occupancy = wr_ptr - rd_ptr;
  assign rd_valid  = (occupancy != '0);
  assign pop       = rd_en && rd_valid;
  assign rd_data   = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_cnt);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NW; i++) begin
      if (i < 32'(wr_cnt))
        mem[wr_ptr[AW-1:0] + AW'(i)] <= wr_data[i];
    end
  end

endmodule

// File: rtl/dir_wreq_serializer.sv
// Captures the four cache dir/tag write channels, packs them into records
// and serializes them over valid/ready. Option: DIR_WREQ_TIMESTAMP_EN.
module dir_wreq_serializer
  import dir_mon_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_dirWReq_valid,
  input  logic [8:0]           io_dirWReq_bits_set,
  input  logic [2:0]           io_dirWReq_bits_way,
  input  logic                 io_dirWReq_bits_data_dirty,
  input  logic [1:0]           io_dirWReq_bits_data_state,
  input  logic [1:0]           io_dirWReq_bits_data_clientStates_0,
  input  logic [1:0]           io_dirWReq_bits_data_clientStates_1,
  input  logic                 io_dirWReq_bits_data_prefetch,
  input  logic                 io_tagWReq_valid,
  input  logic [8:0]           io_tagWReq_bits_set,
  input  logic [2:0]           io_tagWReq_bits_way,
  input  logic [18:0]          io_tagWReq_bits_tag,
  input  logic                 io_clientDirWReq_valid,
  input  logic [6:0]           io_clientDirWReq_bits_set,
  input  logic [2:0]           io_clientDirWReq_bits_way,
  input  logic [1:0]           io_clientDirWReq_bits_data_0_state,
  input  logic [1:0]           io_clientDirWReq_bits_data_0_alias,
  input  logic [1:0]           io_clientDirWReq_bits_data_1_state,
  input  logic [1:0]           io_clientDirWReq_bits_data_1_alias,
  input  logic                 io_clientTagWreq_valid,
  input  logic [6:0]           io_clientTagWreq_bits_set,
  input  logic [2:0]           io_clientTagWreq_bits_way,
  input  logic [20:0]          io_clientTagWreq_bits_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_kind,
  output logic [8:0]           out_set,
  output logic [2:0]           out_way,
  output logic [20:0]          out_payload,
  output logic [31:0]          out_time,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef DIR_WREQ_TIMESTAMP_EN
  localparam int unsigned DW = REC_W;
`else
  localparam int unsigned DW = BODY_W;
`endif

  wreq_body_t                body [NUM_CH];
  logic [NUM_CH-1:0]         ch_valid;
  logic [NUM_CH-1:0][DW-1:0] ch_entry;
  logic [NUM_CH-1:0][DW-1:0] slot;
  logic [2:0]                n_enq;
  logic [2:0]                n_drop;
  logic [AW:0]               occ;
  logic [AW:0]               free_slots;
  logic [DW-1:0]             head;
  wreq_rec_t                 out_rec;
  logic [DROP_W:0]           drop_sum;

  assign ch_valid = {io_clientTagWreq_valid, io_clientDirWReq_valid,
                     io_tagWReq_valid, io_dirWReq_valid};

  always_comb begin
    body[0] = '{kind: DIR, set: io_dirWReq_bits_set, way: io_dirWReq_bits_way,
                payload: PAYLOAD_W'({io_dirWReq_bits_data_prefetch,
                                     io_dirWReq_bits_data_clientStates_1,
                                     io_dirWReq_bits_data_clientStates_0,
                                     io_dirWReq_bits_data_state,
                                     io_dirWReq_bits_data_dirty})};
    body[1] = '{kind: TAG, set: io_tagWReq_bits_set, way: io_tagWReq_bits_way,
                payload: PAYLOAD_W'(io_tagWReq_bits_tag)};
    body[2] = '{kind: CDIR, set: SET_W'(io_clientDirWReq_bits_set),
                way: io_clientDirWReq_bits_way,
                payload: PAYLOAD_W'({io_clientDirWReq_bits_data_1_alias,
                                     io_clientDirWReq_bits_data_1_state,
                                     io_clientDirWReq_bits_data_0_alias,
                                     io_clientDirWReq_bits_data_0_state})};
    body[3] = '{kind: CTAG, set: SET_W'(io_clientTagWreq_bits_set),
                way: io_clientTagWreq_bits_way,
                payload: io_clientTagWreq_bits_tag};
  end

`ifdef DIR_WREQ_TIMESTAMP_EN
  logic [TIME_W-1:0] tcnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tcnt <= '0;
    else          tcnt <= tcnt + 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++)
      ch_entry[i] = {body[i], tcnt};
  end

  assign out_rec = wreq_rec_t'(head);
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++)
      ch_entry[i] = body[i];
  end

  assign out_rec = wreq_rec_t'({head, {TIME_W{1'b0}}});
`endif

  // Free space is judged on start-of-cycle occupancy; a same-cycle dequeue
  // does not make room, so a full FIFO drops everything that cycle.
  assign free_slots = (AW+1)'(DEPTH) - occ;

  always_comb begin
    slot   = '0;
    n_enq  = '0;
    n_drop = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i]) begin
        if (32'(n_enq) < 32'(free_slots)) begin
          slot[n_enq[1:0]] = ch_entry[i];
          n_enq            = n_enq + 3'd1;
        end else begin
          n_drop = n_drop + 3'd1;
        end
      end
    end
  end

  wreq_multi_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .NW    (NUM_CH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_cnt    (n_enq),
    .wr_data   (slot),
    .rd_en     (out_ready),
    .rd_valid  (out_valid),
    .rd_data   (head),
    .occupancy (occ)
  );

  assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (n_drop != '0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  assign out_kind    = out_rec.kind;
  assign out_set     = out_rec.set;
  assign out_way     = out_rec.way;
  assign out_payload = out_rec.payload;
  assign out_time    = out_rec.stamp;

endmodule

// File: tb/tb_dir_wreq_serializer.sv
// Directed and randomized bench for dir_wreq_serializer against a
// queue-based reference model of capture, drop and drain behaviour.
module tb_dir_wreq_serializer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dv, tv, cdv, ctv;
  logic [8:0]  d_set, t_set;
  logic [6:0]  cd_set, ct_set;
  logic [2:0]  d_way, t_way, cd_way, ct_way;
  logic        d_dirty, d_pf;
  logic [1:0]  d_state, d_cs0, d_cs1;
  logic [18:0] t_tag;
  logic [1:0]  cd_s0, cd_a0, cd_s1, cd_a1;
  logic [20:0] ct_tag;
  logic        out_valid, out_ready, overflow;
  logic [1:0]  out_kind;
  logic [8:0]  out_set;
  logic [2:0]  out_way;
  logic [20:0] out_payload;
  logic [31:0] out_time;
  logic [DROP_W-1:0] drop_cnt;

  typedef struct {
    int unsigned kind;
    int unsigned set;
    int unsigned way;
    int unsigned payload;
    int unsigned ts;
  } mrec_t;

  mrec_t       q[$];
  int unsigned m_drop;
  bit          m_ovf;
  int unsigned m_time;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  dir_wreq_serializer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_dirWReq_valid(dv), .io_dirWReq_bits_set(d_set), .io_dirWReq_bits_way(d_way),
    .io_dirWReq_bits_data_dirty(d_dirty), .io_dirWReq_bits_data_state(d_state),
    .io_dirWReq_bits_data_clientStates_0(d_cs0), .io_dirWReq_bits_data_clientStates_1(d_cs1),
    .io_dirWReq_bits_data_prefetch(d_pf),
    .io_tagWReq_valid(tv), .io_tagWReq_bits_set(t_set), .io_tagWReq_bits_way(t_way),
    .io_tagWReq_bits_tag(t_tag),
    .io_clientDirWReq_valid(cdv), .io_clientDirWReq_bits_set(cd_set),
    .io_clientDirWReq_bits_way(cd_way),
    .io_clientDirWReq_bits_data_0_state(cd_s0), .io_clientDirWReq_bits_data_0_alias(cd_a0),
    .io_clientDirWReq_bits_data_1_state(cd_s1), .io_clientDirWReq_bits_data_1_alias(cd_a1),
    .io_clientTagWreq_valid(ctv), .io_clientTagWreq_bits_set(ct_set),
    .io_clientTagWreq_bits_way(ct_way), .io_clientTagWreq_bits_tag(ct_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_set(out_set),
    .out_way(out_way), .out_payload(out_payload), .out_time(out_time),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    mrec_t h;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_kind", 64'(out_kind), 64'(h.kind));
      chk("out_set", 64'(out_set), 64'(h.set));
      chk("out_way", 64'(out_way), 64'(h.way));
      chk("out_payload", 64'(out_payload), 64'(h.payload));
`ifdef DIR_WREQ_TIMESTAMP_EN
      chk("out_time", 64'(out_time), 64'(h.ts));
`else
      chk("out_time", 64'(out_time), 64'd0);
`endif
    end
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic clear_inputs();
    {dv, tv, cdv, ctv} = 4'b0000;
  endtask

  task automatic rand_inputs(input logic [3:0] mask);
    {ctv, cdv, tv, dv} = mask;
    d_set = 9'($urandom); d_way = 3'($urandom); d_dirty = 1'($urandom);
    d_state = 2'($urandom); d_cs0 = 2'($urandom); d_cs1 = 2'($urandom); d_pf = 1'($urandom);
    t_set = 9'($urandom); t_way = 3'($urandom); t_tag = 19'($urandom);
    cd_set = 7'($urandom); cd_way = 3'($urandom);
    cd_s0 = 2'($urandom); cd_a0 = 2'($urandom); cd_s1 = 2'($urandom); cd_a1 = 2'($urandom);
    ct_set = 7'($urandom); ct_way = 3'($urandom); ct_tag = 21'($urandom);
  endtask

  // Reference model of one clock edge: free space from start-of-cycle fill,
  // priority dir > tag > clientDir > clientTag, then the head dequeue.
  task automatic tick();
    mrec_t r[4];
    bit    v[4];
    bit    pop;
    int    f;
    v[0] = dv; v[1] = tv; v[2] = cdv; v[3] = ctv;
    r[0] = '{0, d_set, d_way,
             d_dirty + 2*d_state + 8*d_cs0 + 32*d_cs1 + 128*d_pf, m_time};
    r[1] = '{1, t_set, t_way, t_tag, m_time};
    r[2] = '{2, cd_set, cd_way, cd_s0 + 4*cd_a0 + 16*cd_s1 + 64*cd_a1, m_time};
    r[3] = '{3, ct_set, ct_way, ct_tag, m_time};
    pop = out_ready && (q.size() != 0);
    f = DEPTH - q.size();
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (f > 0) begin
          q.push_back(r[i]);
          f--;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < (2**DROP_W) - 1) m_drop++;
        end
      end
    end
    if (pop) void'(q.pop_front());
    m_time++;
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_time = 0;
  endtask

  initial begin
    clear_inputs();
    rand_inputs(4'b0000);
    out_ready = 1'b1;
    model_reset();

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_kind", 64'(out_kind), 64'd0);
    chk("rst_set", 64'(out_set), 64'd0);
    chk("rst_way", 64'(out_way), 64'd0);
    chk("rst_payload", 64'(out_payload), 64'd0);
    chk("rst_time", 64'(out_time), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single dir write
    clear_inputs();
    dv = 1'b1; d_set = 9'h1A5; d_way = 3'd5; d_dirty = 1'b1; d_state = 2'd2;
    d_cs0 = 2'd1; d_cs1 = 2'd3; d_pf = 1'b1;
    tick();
    chk("dir_set", 64'(out_set), 64'h1A5);
    chk("dir_payload", 64'(out_payload), 64'h0ED);
    clear_inputs();
    tick();
    chk("dir_gone", 64'(out_valid), 64'd0);

    // All four channels in one cycle
    rand_inputs(4'hF);
    cd_set = 7'h7F;
    tick();
    clear_inputs();
    repeat (4) tick();

    // Stall with one tag write per cycle: fill then drop
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      rand_inputs(4'b0010);
      tick();
    end
    clear_inputs();
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    chk("fill_ovf", 64'(overflow), 64'd1);
    tick();
    out_ready = 1'b1;
    repeat (17) tick();

    // 14 queued, four channels valid: two lowest-priority dropped
    out_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rand_inputs(4'b0001 << (i % 4));
      tick();
    end
    rand_inputs(4'hF);
    tick();
    clear_inputs();
    chk("part_drop", 64'(drop_cnt), 64'd4);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    tick();

    // Asynchronous reset with 10 queued
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    model_reset();
    rand_inputs(4'hF);
    @(posedge clock);
    #1;
    chk("arst_ignore", 64'(out_valid), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    rand_inputs(4'b0001);
    tick();
    chk("post_rst_lat", 64'(out_valid), 64'd1);
    clear_inputs();
    tick();

    // Pointer wrap with random back-pressure
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rand_inputs(4'b0001 << $urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) tick();
    chk("drain_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
